func_executor: RTL and testbench



---
 rtl/func_executor_if.sv | 25 ++
 rtl/func_executor.sv | 235 +++++++++++++++++++++++
 tb/tb_func_executor.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_executor_if.sv
// Keyboard-instruction and display-state bundle for func_executor.
// The keyboard side drives the instruction buses; the executor drives the display state.
interface func_executor_if;
  logic [1:0]  func_index;
  logic [3:0]  func1_instruction;
  logic [4:0]  func2_instruction;
  logic [4:0]  func3_instruction;
  logic [2:0]  color;
  logic [9:0]  cursor_x;
  logic [8:0]  cursor_y;
  logic [63:0] tiles;
  logic [3:0]  blank_pos;
  logic        scramble_busy;
  logic        solved;

  modport master (
    output func_index, func1_instruction, func2_instruction, func3_instruction,
    input  color, cursor_x, cursor_y, tiles, blank_pos, scramble_busy, solved
  );

  modport slave (
    input  func_index, func1_instruction, func2_instruction, func3_instruction,
    output color, cursor_x, cursor_y, tiles, blank_pos, scramble_busy, solved
  );
endinterface

// File: rtl/func_executor.sv
// Executes keyboard instructions: fill colour, cursor movement and a 4x4 sliding puzzle.
// Optional FUNC_EXEC_DEBOUNCE_EN inserts per-bit debounce counters after the synchronisers.
module func_executor #(
  parameter int          H_ACTIVE        = 640,
  parameter int          V_ACTIVE        = 480,
  parameter int          STEP_LARGE      = 8,
  parameter int          SCRAMBLE_MOVES  = 64,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          DEBOUNCE_CYCLES = 250000
) (
  input  logic           sysclk,
  input  logic           reset,
  func_executor_if.slave bus
);
  localparam int          NB     = 16;
  localparam int          CNT_W  = $clog2(SCRAMBLE_MOVES + 1);
  localparam logic [63:0] SOLVED = 64'h0FED_CBA9_8765_4321;

  typedef enum logic [0:0] {ST_IDLE, ST_SCRAMBLE} state_t;

  if (LFSR_SEED == 16'h0 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("func_executor: LFSR_SEED must be nonzero and DEBOUNCE_CYCLES positive");
  end

  logic [NB-1:0] raw, sync1_reg, sync2_reg, level;

  assign raw = {bus.func_index, bus.func1_instruction, bus.func2_instruction, bus.func3_instruction};

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef FUNC_EXEC_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  for (genvar gi = 0; gi < NB; gi++) begin : g_debounce
    logic [DB_W-1:0] cnt_reg;
    logic            lvl_reg;
    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
        lvl_reg <= 1'b0;
      end else if (sync2_reg[gi] == lvl_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg <= '0;
        lvl_reg <= sync2_reg[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign level[gi] = lvl_reg;
  end
`else
  assign level = sync2_reg;
`endif

  logic [1:0] func_sel;
  logic [3:0] lvl1, edge1_reg, press1;
  logic [4:0] lvl2, edge2_reg, press2;
  logic [4:0] lvl3, edge3_reg, press3;

  assign func_sel = level[15:14];
  assign lvl1     = level[13:10];
  assign lvl2     = level[9:5];
  assign lvl3     = level[4:0];

  // Edge registers of an inactive bus sit at zero, so a bit held across a switch counts as a press.
  assign press1 = (func_sel == 2'd0) ? (lvl1 & ~edge1_reg) : '0;
  assign press2 = (func_sel == 2'd1) ? (lvl2 & ~edge2_reg) : '0;
  assign press3 = (func_sel == 2'd2) ? (lvl3 & ~edge3_reg) : '0;

  logic       set_press_reg, step_sel_reg;
  logic [2:0] rgb_reg;
  logic [3:0] cur_press_reg;
  logic [4:0] puz_press_reg;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      edge1_reg     <= '0;
      edge2_reg     <= '0;
      edge3_reg     <= '0;
      set_press_reg <= 1'b0;
      rgb_reg       <= '0;
      cur_press_reg <= '0;
      step_sel_reg  <= 1'b0;
      puz_press_reg <= '0;
    end else begin
      edge1_reg     <= (func_sel == 2'd0) ? lvl1 : '0;
      edge2_reg     <= (func_sel == 2'd1) ? lvl2 : '0;
      edge3_reg     <= (func_sel == 2'd2) ? lvl3 : '0;
      set_press_reg <= press1[0];
      rgb_reg       <= lvl1[3:1];
      cur_press_reg <= press2[3:0];
      step_sel_reg  <= lvl2[4];
      puz_press_reg <= press3;
    end
  end

  logic [2:0]  color_reg;
  logic [9:0]  x_reg, x_next;
  logic [8:0]  y_reg, y_next;
  logic [10:0] step, x_wide, y_wide, x_east, x_west, y_south, y_north;

  assign step    = step_sel_reg ? 11'(STEP_LARGE) : 11'd1;
  assign x_wide  = {1'b0, x_reg};
  assign y_wide  = {2'b0, y_reg};
  assign x_east  = (x_wide + step >= 11'(H_ACTIVE)) ? x_wide + step - 11'(H_ACTIVE) : x_wide + step;
  assign x_west  = (x_wide < step) ? x_wide + 11'(H_ACTIVE) - step : x_wide - step;
  assign y_south = (y_wide + step >= 11'(V_ACTIVE)) ? y_wide + step - 11'(V_ACTIVE) : y_wide + step;
  assign y_north = (y_wide < step) ? y_wide + 11'(V_ACTIVE) - step : y_wide - step;

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (cur_press_reg[3] && !cur_press_reg[2]) x_next = x_east[9:0];
    if (cur_press_reg[2] && !cur_press_reg[3]) x_next = x_west[9:0];
    if (cur_press_reg[0] && !cur_press_reg[1]) y_next = y_south[8:0];
    if (cur_press_reg[1] && !cur_press_reg[0]) y_next = y_north[8:0];
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      color_reg <= 3'b111;
      x_reg     <= 10'(H_ACTIVE / 2);
      y_reg     <= 9'(V_ACTIVE / 2);
    end else begin
      if (set_press_reg) color_reg <= rgb_reg;
      x_reg <= x_next;
      y_reg <= y_next;
    end
  end

  logic [15:0] lfsr_reg;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) lfsr_reg <= LFSR_SEED;
    else       lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  state_t           state_reg;
  logic             busy_reg, solved_reg;
  logic [CNT_W-1:0] move_cnt_reg;
  logic [3:0]       tile_reg [16];
  logic [3:0]       blank_reg, neighbour;
  logic [63:0]      tiles_flat;
  logic [1:0]       move_dir;
  logic             move_req, legal, do_move;

  for (genvar gi = 0; gi < 16; gi++) begin : g_tiles
    assign tiles_flat[4*gi +: 4] = tile_reg[gi];
  end

  // Direction codes: 0 east, 1 west, 2 north, 3 south; user presses use fixed priority.
  always_comb begin
    move_req = 1'b0;
    move_dir = 2'd0;
    if (state_reg == ST_SCRAMBLE) begin
      move_req = 1'b1;
      move_dir = lfsr_reg[1:0];
    end else if (puz_press_reg[4]) begin
      move_req = 1'b1;
      move_dir = 2'd0;
    end else if (puz_press_reg[3]) begin
      move_req = 1'b1;
      move_dir = 2'd1;
    end else if (puz_press_reg[2]) begin
      move_req = 1'b1;
      move_dir = 2'd2;
    end else if (puz_press_reg[1]) begin
      move_req = 1'b1;
      move_dir = 2'd3;
    end
  end

  always_comb begin
    legal     = 1'b0;
    neighbour = blank_reg;
    case (move_dir)
      2'd0: begin legal = (blank_reg[1:0] != 2'd3); neighbour = blank_reg + 4'd1; end
      2'd1: begin legal = (blank_reg[1:0] != 2'd0); neighbour = blank_reg - 4'd1; end
      2'd2: begin legal = (blank_reg[3:2] != 2'd0); neighbour = blank_reg - 4'd4; end
      default: begin legal = (blank_reg[3:2] != 2'd3); neighbour = blank_reg + 4'd4; end
    endcase
  end

  assign do_move = move_req && legal;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      busy_reg     <= 1'b0;
      move_cnt_reg <= '0;
      blank_reg    <= 4'd15;
      solved_reg   <= 1'b1;
      for (int i = 0; i < 16; i++) tile_reg[i] <= (i == 15) ? 4'd0 : 4'(i + 1);
    end else begin
      solved_reg <= (tiles_flat == SOLVED);
      if (do_move) begin
        tile_reg[blank_reg] <= tile_reg[neighbour];
        tile_reg[neighbour] <= 4'd0;
        blank_reg           <= neighbour;
      end
      case (state_reg)
        ST_IDLE: begin
          if (puz_press_reg[0]) begin
            state_reg    <= ST_SCRAMBLE;
            busy_reg     <= 1'b1;
            move_cnt_reg <= CNT_W'(SCRAMBLE_MOVES);
          end
        end
        default: begin
          move_cnt_reg <= move_cnt_reg - 1'b1;
          if (move_cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.color         = color_reg;
  assign bus.cursor_x      = x_reg;
  assign bus.cursor_y      = y_reg;
  assign bus.tiles         = tiles_flat;
  assign bus.blank_pos     = blank_reg;
  assign bus.scramble_busy = busy_reg;
  assign bus.solved        = solved_reg;
endmodule

// File: tb/tb_func_executor.sv
// Directed-vector bench for func_executor: table of instruction pulses plus
// hand sequences for latency, function switching, cursor wrap and scramble/reset.
module tb_func_executor;
  logic sysclk = 1'b0;
  logic reset;

  func_executor_if bus();

  func_executor dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  localparam logic [63:0] SOLVED_T = 64'h0FED_CBA9_8765_4321;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_color"},  64'(bus.color), 64'd7);
    chk({tag, "_x"},      64'(bus.cursor_x), 64'd320);
    chk({tag, "_y"},      64'(bus.cursor_y), 64'd240);
    chk({tag, "_tiles"},  bus.tiles, SOLVED_T);
    chk({tag, "_blank"},  64'(bus.blank_pos), 64'd15);
    chk({tag, "_busy"},   64'(bus.scramble_busy), 64'd0);
    chk({tag, "_solved"}, 64'(bus.solved), 64'd1);
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded at reset, steps every clock.
  logic [15:0] m_lfsr;
  always @(posedge sysclk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  logic [3:0] m_tile [16];
  int         m_blank;

  task automatic model_move(input logic [1:0] d);
    int  r, c, nb;
    logic ok;
    r  = m_blank / 4;
    c  = m_blank % 4;
    ok = 1'b0;
    nb = m_blank;
    case (d)
      2'd0: begin ok = (c != 3); nb = m_blank + 1; end
      2'd1: begin ok = (c != 0); nb = m_blank - 1; end
      2'd2: begin ok = (r != 0); nb = m_blank - 4; end
      default: begin ok = (r != 3); nb = m_blank + 4; end
    endcase
    if (ok) begin
      m_tile[m_blank] = m_tile[nb];
      m_tile[nb]      = 4'd0;
      m_blank         = nb;
    end
  endtask

  function automatic logic [63:0] model_pack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = m_tile[i];
    return v;
  endfunction

  typedef struct {
    logic [1:0] fi;
    logic [3:0] f1;
    logic [4:0] f2;
    logic [4:0] f3;
    logic [2:0] color;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] blank;
    logic       solved;
  } vec_t;

  vec_t vt [21];

  task automatic pulse2(input logic [4:0] v);
    @(negedge sysclk) bus.func2_instruction = v;
    @(negedge sysclk);
    @(negedge sysclk) bus.func2_instruction = 5'd0;
    @(negedge sysclk);
  endtask

  int busy_cnt;

  initial begin
    //        fi    f1       f2        f3        col  x    y    blk  sol
    vt[0]  = '{2'd0, 4'b1011, 5'b00000, 5'b00000, 3'd5, 320, 240, 15, 1'b1};
    vt[1]  = '{2'd0, 4'b0111, 5'b00000, 5'b00000, 3'd3, 320, 240, 15, 1'b1};
    vt[2]  = '{2'd1, 4'b0000, 5'b01000, 5'b00000, 3'd3, 321, 240, 15, 1'b1};
    vt[3]  = '{2'd1, 4'b0000, 5'b11000, 5'b00000, 3'd3, 329, 240, 15, 1'b1};
    vt[4]  = '{2'd1, 4'b0000, 5'b00100, 5'b00000, 3'd3, 328, 240, 15, 1'b1};
    vt[5]  = '{2'd1, 4'b0000, 5'b00010, 5'b00000, 3'd3, 328, 239, 15, 1'b1};
    vt[6]  = '{2'd1, 4'b0000, 5'b10001, 5'b00000, 3'd3, 328, 247, 15, 1'b1};
    vt[7]  = '{2'd1, 4'b0000, 5'b01100, 5'b00000, 3'd3, 328, 247, 15, 1'b1};
    vt[8]  = '{2'd1, 4'b0000, 5'b00011, 5'b00000, 3'd3, 328, 247, 15, 1'b1};
    vt[9]  = '{2'd2, 4'b0000, 5'b00000, 5'b10000, 3'd3, 328, 247, 15, 1'b1};
    vt[10] = '{2'd2, 4'b0000, 5'b00000, 5'b01000, 3'd3, 328, 247, 14, 1'b0};
    vt[11] = '{2'd2, 4'b0000, 5'b00000, 5'b00100, 3'd3, 328, 247, 10, 1'b0};
    vt[12] = '{2'd2, 4'b0000, 5'b00000, 5'b00010, 3'd3, 328, 247, 14, 1'b0};
    vt[13] = '{2'd2, 4'b0000, 5'b00000, 5'b10000, 3'd3, 328, 247, 15, 1'b1};
    vt[14] = '{2'd2, 4'b0000, 5'b00000, 5'b00010, 3'd3, 328, 247, 15, 1'b1};
    vt[15] = '{2'd2, 4'b0000, 5'b00000, 5'b01100, 3'd3, 328, 247, 14, 1'b0};
    vt[16] = '{2'd2, 4'b0000, 5'b00000, 5'b00110, 3'd3, 328, 247, 10, 1'b0};
    vt[17] = '{2'd2, 4'b0000, 5'b00000, 5'b00010, 3'd3, 328, 247, 14, 1'b0};
    vt[18] = '{2'd2, 4'b0000, 5'b00000, 5'b10000, 3'd3, 328, 247, 15, 1'b1};
    vt[19] = '{2'd0, 4'b0000, 5'b00000, 5'b00000, 3'd3, 328, 247, 15, 1'b1};
    vt[20] = '{2'd3, 4'b1111, 5'b11000, 5'b01000, 3'd3, 328, 247, 15, 1'b1};

    reset = 1'b1;
    bus.func_index = 2'd3;
    bus.func1_instruction = 4'd0;
    bus.func2_instruction = 5'd0;
    bus.func3_instruction = 5'd0;
    repeat (3) @(negedge sysclk);
    chk_reset("reset");
    reset = 1'b0;

    foreach (vt[i]) begin
      @(negedge sysclk);
      bus.func_index = vt[i].fi;
      bus.func1_instruction = vt[i].f1;
      bus.func2_instruction = vt[i].f2;
      bus.func3_instruction = vt[i].f3;
      repeat (2) @(negedge sysclk);
      bus.func1_instruction = 4'd0;
      bus.func2_instruction = 5'd0;
      bus.func3_instruction = 5'd0;
      repeat (5) @(negedge sysclk);
      chk($sformatf("v%0d_color", i), 64'(bus.color), 64'(vt[i].color));
      chk($sformatf("v%0d_x", i), 64'(bus.cursor_x), 64'(vt[i].x));
      chk($sformatf("v%0d_y", i), 64'(bus.cursor_y), 64'(vt[i].y));
      chk($sformatf("v%0d_blank", i), 64'(bus.blank_pos), 64'(vt[i].blank));
      chk($sformatf("v%0d_solved", i), 64'(bus.solved), 64'(vt[i].solved));
      if (vt[i].solved) chk($sformatf("v%0d_tiles", i), bus.tiles, SOLVED_T);
    end

    // Colour load lands exactly three edges after the set rise; holding set does nothing more.
    bus.func_index = 2'd0;
    repeat (4) @(negedge sysclk);
    bus.func1_instruction = 4'b1001;
    repeat (3) @(negedge sysclk);
    chk("color_lat_n2", 64'(bus.color), 64'd3);
    @(negedge sysclk);
    chk("color_lat_n3", 64'(bus.color), 64'd4);
    bus.func1_instruction = 4'b0101;
    repeat (5) @(negedge sysclk);
    chk("color_hold", 64'(bus.color), 64'd4);
    bus.func1_instruction = 4'd0;

    // Tile move at N+3, solved flag one cycle later.
    bus.func_index = 2'd2;
    repeat (4) @(negedge sysclk);
    bus.func3_instruction = 5'b01000;
    repeat (3) @(negedge sysclk);
    chk("move_lat_n2_blank", 64'(bus.blank_pos), 64'd15);
    @(negedge sysclk);
    chk("move_lat_n3_blank", 64'(bus.blank_pos), 64'd14);
    chk("move_lat_n3_solved", 64'(bus.solved), 64'd1);
    @(negedge sysclk);
    chk("move_lat_n4_solved", 64'(bus.solved), 64'd0);
    chk("move_tiles", bus.tiles, 64'hF0ED_CBA9_8765_4321);
    bus.func3_instruction = 5'd0;
    repeat (2) @(negedge sysclk);
    bus.func3_instruction = 5'b10000;
    repeat (2) @(negedge sysclk);
    bus.func3_instruction = 5'd0;
    repeat (5) @(negedge sysclk);
    chk("move_back_solved", 64'(bus.solved), 64'd1);

    // A bit held high across a function switch is a press; its release is not.
    bus.func_index = 2'd0;
    bus.func2_instruction = 5'b01000;
    repeat (6) @(negedge sysclk);
    chk("switch_inactive_x", 64'(bus.cursor_x), 64'd328);
    bus.func_index = 2'd1;
    repeat (6) @(negedge sysclk);
    chk("switch_active_x", 64'(bus.cursor_x), 64'd329);
    bus.func2_instruction = 5'd0;
    repeat (6) @(negedge sysclk);
    chk("switch_release_x", 64'(bus.cursor_x), 64'd329);

    // Walk the cursor to 636 and wrap both ways with the large step.
    for (int i = 0; i < 38; i++) pulse2(5'b11000);
    for (int i = 0; i < 3; i++) pulse2(5'b01000);
    repeat (4) @(negedge sysclk);
    chk("wrap_pre_x", 64'(bus.cursor_x), 64'd636);
    pulse2(5'b11000);
    repeat (4) @(negedge sysclk);
    chk("wrap_east_x", 64'(bus.cursor_x), 64'd4);
    pulse2(5'b10100);
    repeat (4) @(negedge sysclk);
    chk("wrap_west_x", 64'(bus.cursor_x), 64'd636);
    pulse2(5'b11100);
    repeat (4) @(negedge sysclk);
    chk("cancel_ew_x", 64'(bus.cursor_x), 64'd636);
    pulse2(5'b10010);
    repeat (4) @(negedge sysclk);
    chk("north_y", 64'(bus.cursor_y), 64'd239);

    // Scramble from a solved board against the replayed LFSR.
    bus.func_index = 2'd2;
    repeat (4) @(negedge sysclk);
    chk("scr_start_solved", 64'(bus.solved), 64'd1);
    for (int i = 0; i < 16; i++) m_tile[i] = (i == 15) ? 4'd0 : 4'(i + 1);
    m_blank = 15;
    bus.func3_instruction = 5'b00001;
    @(negedge sysclk);
    @(negedge sysclk) bus.func3_instruction = 5'd0;
    @(negedge sysclk);
    chk("scr_busy_pre", 64'(bus.scramble_busy), 64'd0);
    @(negedge sysclk);
    chk("scr_busy_rise", 64'(bus.scramble_busy), 64'd1);
    busy_cnt = bus.scramble_busy ? 1 : 0;
    for (int k = 1; k <= 64; k++) begin
      model_move(m_lfsr[1:0]);
      if (k == 5) bus.func3_instruction = 5'b10001;
      if (k == 7) bus.func3_instruction = 5'd0;
      @(negedge sysclk);
      if (bus.scramble_busy) busy_cnt++;
    end
    chk("scr_busy_cycles", 64'(busy_cnt), 64'd64);
    chk("scr_busy_fall", 64'(bus.scramble_busy), 64'd0);
    chk("scr_tiles", bus.tiles, model_pack());
    chk("scr_blank", 64'(bus.blank_pos), 64'(m_blank));
    @(negedge sysclk);
    chk("scr_solved", 64'(bus.solved), 64'(model_pack() == SOLVED_T));

    // Reset mid-scramble clears everything at once and nothing resumes.
    bus.func3_instruction = 5'b00001;
    repeat (2) @(negedge sysclk);
    bus.func3_instruction = 5'd0;
    repeat (20) @(negedge sysclk);
    chk("mid_busy", 64'(bus.scramble_busy), 64'd1);
    #2 reset = 1'b1;
    #1 chk_reset("mid_reset");
    @(negedge sysclk) reset = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge sysclk);
      if (bus.scramble_busy) busy_cnt++;
    end
    chk("post_reset_busy", 64'(busy_cnt), 64'd0);
    chk("post_reset_tiles", bus.tiles, SOLVED_T);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
